// File: rtl/iob_merge_pkg.sv
// Shared definitions for the two-master IOb merge: FSM state encoding and
// master index constants used by the merge top and its round-robin arbiter.
package iob_merge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK  = 2'd1,
      ST_RWAIT = 2'd2
   } merge_state_e;

   localparam logic MST0 = 1'b0;
   localparam logic MST1 = 1'b1;

   // Reset value of the last-grant pointer: master 0 wins the first tie.
   localparam logic RST_LAST = MST1;

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the request pair,
// with a last-grant pointer register advanced whenever a grant is consumed.
module iob_rr_arb2
   import iob_merge_pkg::*;
(
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic       cke_i,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       upd_idx_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o,
   output logic       last_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt_vld_o = |req_i;
      gnt_idx_o = MST0;
      if (&req_i) begin
         gnt_idx_o = ~last_q;
      end else if (req_i[1]) begin
         gnt_idx_o = MST1;
      end
      last_d = upd_i ? upd_idx_i : last_q;
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         last_q <= RST_LAST;
      end else if (cke_i) begin
         last_q <= last_d;
      end
   end

   assign last_o = last_q;

endmodule

// File: rtl/iob_merge2.sv
// Merges a data-bus master (m0) and an instruction-bus master (m1) onto one
// IOb slave; requests and responses pass through combinationally.
module iob_merge2
   import iob_merge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic                cke_i,

   input  logic                m0_avalid_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_wstrb_i,
   output logic [DATA_W-1:0]   m0_rdata_o,
   output logic                m0_rvalid_o,
   output logic                m0_ready_o,

   input  logic                m1_avalid_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_wstrb_i,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                m1_rvalid_o,
   output logic                m1_ready_o,

   output logic                s_avalid_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   output logic [DATA_W/8-1:0] s_wstrb_o,
   input  logic [DATA_W-1:0]   s_rdata_i,
   input  logic                s_rvalid_i,
   input  logic                s_ready_i,

   output logic [1:0]          dbg_state_o
);

   // Handshake: a request transfers on the cycle s_avalid_o & s_ready_i is
   // high; a granted master sees ready_o = s_ready_i, and must hold its
   // request until then. Reads get exactly one rvalid, writes none.

   merge_state_e state_q, state_d;
   logic         owner_q, owner_d;

   logic run;
   logic rsp_hit;
   logic arb_en;
   logic arb_vld;
   logic arb_idx;
   logic arb_last;
   logic gnt_vld;
   logic gnt_idx;
   logic accept;
   logic is_read;

   iob_rr_arb2 u_arb (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .cke_i     (cke_i),
      .req_i     ({m1_avalid_i, m0_avalid_i}),
      .upd_i     (accept),
      .upd_idx_i (gnt_idx),
      .gnt_vld_o (arb_vld),
      .gnt_idx_o (arb_idx),
      .last_o    (arb_last)
   );

   // Grant selection: LOCK pins the owner; IDLE, and RWAIT in the cycle its
   // rvalid arrives, take a fresh round-robin grant so reads chain without
   // a bubble. Nothing is issued while in reset or clock-disabled.
   always_comb begin
      run     = arst_i & cke_i;
      rsp_hit = run && (state_q == ST_RWAIT) && s_rvalid_i;
      arb_en  = run && ((state_q == ST_IDLE) || rsp_hit);
      gnt_vld = 1'b0;
      gnt_idx = owner_q;
      if (run && (state_q == ST_LOCK)) begin
         gnt_vld = 1'b1;
      end else if (arb_en && arb_vld) begin
         gnt_vld = 1'b1;
         gnt_idx = arb_idx;
      end
   end

   always_comb begin
      s_avalid_o = 1'b0;
      s_addr_o   = '0;
      s_wdata_o  = '0;
      s_wstrb_o  = '0;
      if (gnt_vld) begin
         if (gnt_idx == MST1) begin
            s_avalid_o = m1_avalid_i;
            s_addr_o   = m1_addr_i;
            s_wdata_o  = m1_wdata_i;
            s_wstrb_o  = m1_wstrb_i;
         end else begin
            s_avalid_o = m0_avalid_i;
            s_addr_o   = m0_addr_i;
            s_wdata_o  = m0_wdata_i;
            s_wstrb_o  = m0_wstrb_i;
         end
      end
   end

   assign m0_ready_o  = gnt_vld && (gnt_idx == MST0) && s_ready_i;
   assign m1_ready_o  = gnt_vld && (gnt_idx == MST1) && s_ready_i;
   assign m0_rvalid_o = rsp_hit && (owner_q == MST0);
   assign m1_rvalid_o = rsp_hit && (owner_q == MST1);
   assign m0_rdata_o  = s_rdata_i;
   assign m1_rdata_o  = s_rdata_i;

   assign accept  = s_avalid_o & s_ready_i;
   assign is_read = ~|s_wstrb_o;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ST_IDLE, ST_RWAIT: begin
            if (arb_en) begin
               state_d = ST_IDLE;
               if (gnt_vld) begin
                  owner_d = gnt_idx;
                  if (!accept) begin
                     state_d = ST_LOCK;
                  end else if (is_read) begin
                     state_d = ST_RWAIT;
                  end
               end
            end
         end
         ST_LOCK: begin
            if (accept) begin
               state_d = is_read ? ST_RWAIT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_q <= ST_IDLE;
         owner_q <= MST0;
      end else if (cke_i) begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   assign dbg_state_o = state_q;

   logic unused_last;
   assign unused_last = arb_last;

endmodule

// File: doc/iob_merge2.md
IOB_MERGE2 -- requirements
Module: iob_merge2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; DATA_W/8 strobe bits.
REQ-003 SHALL have port clk_i, input, 1, system clock; all state on rising edge.
REQ-004 SHALL have port arst_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port cke_i, input, 1, clock enable; state holds when low.
REQ-006 SHALL have ports m0_avalid_i/m0_addr_i/m0_wdata_i/m0_wstrb_i, input, 1/ADDR_W/DATA_W/DATA_W/8, master 0 (data bus) request.
REQ-007 SHALL have ports m0_rdata_o/m0_rvalid_o/m0_ready_o, output, DATA_W/1/1, master 0 response.
REQ-008 SHALL have ports m1_* identical to m0_*, master 1 (instruction bus).
REQ-009 SHALL have ports s_avalid_o/s_addr_o/s_wdata_o/s_wstrb_o, output, 1/ADDR_W/DATA_W/DATA_W/8, merged request toward external memory.
REQ-010 SHALL have ports s_rdata_i/s_rvalid_i/s_ready_i, input, DATA_W/1/1, slave response.

Function
REQ-011 SHALL merge two IOb masters onto one slave; transfer accepted when s_avalid_o & s_ready_i.
REQ-012 SHALL treat a request as a write when wstrb != 0 (no rvalid expected), read when wstrb == 0 (exactly one rvalid expected).
REQ-013 SHALL use states IDLE, LOCK (granted request not yet accepted), RWAIT (read accepted, rvalid outstanding).
REQ-014 IDLE: grant combinational round-robin; both requesting -> master not granted last; one requesting -> that master.
REQ-015 IDLE->LOCK when granted and s_ready_i low; LOCK holds grant, unaffected by other master, until accept.
REQ-016 Accept of read -> RWAIT; accept of write -> IDLE; last-grant pointer updates on every accept.
REQ-017 RWAIT: s_avalid_o low, both mN_ready_o low; on s_rvalid_i route s_rdata_i/rvalid to owning master only, same cycle, then IDLE.
REQ-018 SHALL allow new grant in the cycle s_rvalid_i is seen in RWAIT (zero-bubble back-to-back reads).
REQ-019 Granted master's ready_o SHALL equal s_ready_i; non-granted ready_o SHALL be 0.
REQ-020 s_addr_o/s_wdata_o/s_wstrb_o SHALL mux granted master; 0 when no grant.
REQ-021 rvalid_o of non-owner SHALL be 0; rdata_o SHALL be s_rdata_i unqualified.
REQ-022 s_rvalid_i outside RWAIT SHALL be ignored.
REQ-023 Request-to-slave latency SHALL be 0 cycles (combinational); response latency 0 cycles.

Reset
REQ-024 On arst_i low: state IDLE, last-grant = master 1 (master 0 wins first tie), owner = 0.
REQ-025 Reset outputs: s_avalid_o 0, all ready_o 0, all rvalid_o 0, s_addr/wdata/wstrb 0.
REQ-026 Reset mid-RWAIT SHALL drop outstanding read; late s_rvalid_i after release ignored.

Structure
REQ-027 State encodings and master index constants SHALL live in shared package iob_merge_pkg.
REQ-028 One sub-module iob_rr_arb2 (2-way round-robin grant, pointer register) SHALL be instantiated.
REQ-029 No buffering beyond state, owner and pointer registers; target 150-250 RTL lines.

Verification
REQ-030 m0 read addr 0x100 alone, slave ready=1, rvalid next cycle data 0xDEADBEEF -> m0_rdata 0xDEADBEEF, m1_rvalid never 1.
REQ-031 m0 and m1 request same cycle from reset, ready=1 -> m0 granted first, m1 next; 20 contested cycles -> strict alternation.
REQ-032 m1 read held, s_ready_i low 3 cycles while m0 asserts write -> s_addr_o stays m1 address until accept; m0 granted after m1 rvalid.
REQ-033 m0 write wstrb=0xF then immediate m1 read -> no RWAIT after write, m1 accepted next cycle.
REQ-034 Back-to-back reads, rvalid arriving with next request -> accepted same cycle, no bubble.
REQ-035 arst_i low during RWAIT, then spurious s_rvalid_i -> all outputs 0, no rvalid_o pulse.
